// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word and cache-line widths plus the
// state encoding and line-address helpers used by the L2 write buffer.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  // A line is 16 bytes, so the line tag is the upper 12 bits of a byte address.
  localparam int unsigned L2WB_OFFSET_W = 4;
  localparam int unsigned L2WB_TAG_W    = 16 - L2WB_OFFSET_W;

  typedef logic [L2WB_TAG_W-1:0] lc3b_l2wb_tag;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ_MEM = 2'd1,
    DRAIN    = 2'd2,
    RESP     = 2'd3
  } lc3b_l2wb_state;

  // Rebuild a line-aligned byte address from a line tag.
  function automatic lc3b_word l2wb_line_base(input lc3b_l2wb_tag tag);
    return {tag, {L2WB_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/write_buffer_entry.sv
// Single-entry line buffer: holds one evicted line (valid, tag, data) and
// reports a combinational hit against the tag of the current request.
module write_buffer_entry
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clear,
  input  logic [11:0]  load_tag,
  input  logic [127:0] load_data,
  input  logic [11:0]  lookup_tag,
  output logic         valid,
  output logic [11:0]  tag,
  output logic [127:0] data,
  output logic         hit
);

  logic           valid_q, valid_d;
  lc3b_l2wb_tag   tag_q, tag_d;
  lc3b_cache_line data_q, data_d;

  // Next entry contents: a load overwrites the line, a clear only drops valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      tag_d   = load_tag;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers; reset discards whatever line was buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;
  assign hit   = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/l2_write_buffer.sv
// L2-side responder for the victim cache. Evicted lines land in a one-entry
// write buffer so writes complete without waiting on memory; reads hitting the
// buffered line are served locally, misses go to physical memory, and the
// buffer drains to memory whenever the request port is idle.
module l2_write_buffer
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  l2_address,
  input  logic [127:0] l2_wdata,
  input  logic         l2_read,
  input  logic         l2_write,
  output logic [127:0] l2_rdata,
  output logic         l2_mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  lc3b_l2wb_state state_q, state_d;
  lc3b_cache_line l2_rdata_q, l2_rdata_d;
  logic           l2_mem_resp_q, l2_mem_resp_d;
  logic           pmem_read_q, pmem_read_d;
  logic           pmem_write_q, pmem_write_d;
  lc3b_word       pmem_address_q, pmem_address_d;
  lc3b_cache_line pmem_wdata_q, pmem_wdata_d;

  lc3b_l2wb_tag   req_tag;
  logic           buf_load;
  logic           buf_clear;
  logic           buf_valid;
  logic           buf_hit;
  lc3b_l2wb_tag   buf_tag;
  lc3b_cache_line buf_data;
  logic           start_drain;

  // The byte offset within a line never matters here: all traffic is whole lines.
  logic unused_offset_bits;
  assign unused_offset_bits = ^l2_address[3:0];

  assign req_tag = l2_address[15:4];

  write_buffer_entry u_entry (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_tag   (req_tag),
    .load_data  (l2_wdata),
    .lookup_tag (req_tag),
    .valid      (buf_valid),
    .tag        (buf_tag),
    .data       (buf_data),
    .hit        (buf_hit)
  );

  // Next-state and next-output logic. Outputs are registered, so every strobe
  // change is decided one cycle ahead here and simply held in the flops.
  always_comb begin
    state_d        = state_q;
    l2_rdata_d     = l2_rdata_q;
    l2_mem_resp_d  = 1'b0;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    start_drain    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (l2_write) begin
          // Write wins over a simultaneous read; a conflicting line must leave first.
          if (!buf_valid || buf_hit) begin
            buf_load      = 1'b1;
            l2_mem_resp_d = 1'b1;
            state_d       = RESP;
          end else begin
            start_drain = 1'b1;
          end
        end else if (l2_read) begin
          if (buf_hit) begin
            l2_rdata_d    = buf_data;
            l2_mem_resp_d = 1'b1;
            state_d       = RESP;
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = l2wb_line_base(req_tag);
            state_d        = READ_MEM;
          end
        end else if (buf_valid) begin
          start_drain = 1'b1;
        end

        if (start_drain) begin
          pmem_write_d   = 1'b1;
          pmem_address_d = l2wb_line_base(buf_tag);
          pmem_wdata_d   = buf_data;
          state_d        = DRAIN;
        end
      end

      READ_MEM: begin
        if (pmem_resp) begin
          pmem_read_d   = 1'b0;
          l2_rdata_d    = pmem_rdata;
          l2_mem_resp_d = 1'b1;
          state_d       = RESP;
        end
      end

      DRAIN: begin
        // Any request that arrived meanwhile is picked up again from IDLE.
        if (pmem_resp) begin
          pmem_write_d = 1'b0;
          buf_clear    = 1'b1;
          state_d      = IDLE;
        end
      end

      RESP: begin
        // Requester drops its level request during this cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops memory strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      l2_rdata_q     <= '0;
      l2_mem_resp_q  <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      l2_rdata_q     <= l2_rdata_d;
      l2_mem_resp_q  <= l2_mem_resp_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign l2_rdata     = l2_rdata_q;
  assign l2_mem_resp  = l2_mem_resp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: the driver queues expected responses and
// expected memory transactions; a response monitor and a memory model pop and
// compare them independently of the driver.
module tb_l2_write_buffer;

  localparam logic [127:0] LINE_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] LINE_B = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [127:0] LINE_C = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
  localparam logic [127:0] LINE_D = 128'hDDDD_0D0D_DDDD_1D1D_DDDD_2D2D_DDDD_3D3D;
  localparam logic [127:0] LINE_E = 128'hEEEE_9999_EEEE_AAAA_EEEE_BBBB_EEEE_CCCC;
  localparam logic [127:0] LINE_M = 128'h4000_FEED_4000_BEEF_4000_CAFE_4000_F00D;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_rdata;
  logic         l2_mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  typedef struct {
    bit           is_read;
    logic [127:0] rdata;
    int           lat;
    int           issue_cyc;
  } resp_exp_t;

  typedef struct {
    bit           is_write;
    logic [15:0]  addr;
    logic [127:0] data;
    int           lat;
  } mem_exp_t;

  resp_exp_t exp_resp[$];
  mem_exp_t  exp_mem[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mem_busy = 1'b0;

  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  l2_write_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_rdata     (l2_rdata),
    .l2_mem_resp  (l2_mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  task automatic waitResp();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (l2_mem_resp) seen = 1'b1;
    end
    if (!seen) checkOutput("resp_timeout", 128'(l2_mem_resp), 128'd1);
  endtask

  // Drive one request and queue its expected response; return once it responds.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [127:0] wdata, input bit exp_read,
                               input logic [127:0] exp_rdata, input int exp_lat);
    resp_exp_t e;
    @(posedge clk);
    #1;
    l2_read    = rd;
    l2_write   = wr;
    l2_address = addr;
    l2_wdata   = wdata;
    e.is_read   = exp_read;
    e.rdata     = exp_rdata;
    e.lat       = exp_lat;
    e.issue_cyc = cyc;
    exp_resp.push_back(e);
    waitResp();
  endtask

  task automatic idleReq();
    @(posedge clk);
    #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic expectMem(input bit is_write, input logic [15:0] addr,
                           input logic [127:0] data, input int lat);
    mem_exp_t m;
    m.is_write = is_write;
    m.addr     = addr;
    m.data     = data;
    m.lat      = lat;
    exp_mem.push_back(m);
  endtask

  task automatic waitQuiet();
    bit quiet;
    quiet = 1'b0;
    for (int k = 0; k < 300 && !quiet; k++) begin
      @(negedge clk);
      if (exp_mem.size() == 0 && !mem_busy && !pmem_read && !pmem_write) quiet = 1'b1;
    end
    if (!quiet) checkOutput("quiet_timeout", 128'(exp_mem.size()), 128'd0);
  endtask

  // Response monitor: every l2_mem_resp pulse must match the oldest expectation.
  initial begin
    resp_exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && l2_mem_resp) begin
        if (exp_resp.size() == 0) begin
          checkOutput("resp_unexpected", 128'(l2_mem_resp), 128'd0);
        end else begin
          e = exp_resp.pop_front();
          checkOutput("resp_latency", 128'(cyc - e.issue_cyc), 128'(e.lat));
          if (e.is_read) checkOutput("resp_rdata", l2_rdata, e.rdata);
        end
      end
    end
  end

  // Memory model: checks each strobe against the expected transaction and
  // answers with a one-cycle pmem_resp after the queued latency.
  initial begin
    mem_exp_t    m;
    logic [15:0] a0;
    bit          w0;
    bit          aborted;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (pmem_read || pmem_write)) begin
        mem_busy = 1'b1;
        checkOutput("pmem_exclusive", 128'(pmem_read && pmem_write), 128'd0);
        if (exp_mem.size() == 0) begin
          checkOutput("pmem_unexpected", 128'(pmem_read || pmem_write), 128'd0);
          m.is_write = pmem_write;
          m.addr     = pmem_address;
          m.data     = '0;
          m.lat      = 1;
        end else begin
          m = exp_mem.pop_front();
          checkOutput("pmem_kind", 128'(pmem_write), 128'(m.is_write));
          checkOutput("pmem_address", 128'(pmem_address), 128'(m.addr));
          if (m.is_write) checkOutput("pmem_wdata", pmem_wdata, m.data);
        end
        w0      = pmem_write;
        a0      = pmem_address;
        aborted = 1'b0;
        for (int k = 0; k < m.lat && !aborted; k++) begin
          @(posedge clk);
          if (!reset_n) aborted = 1'b1;
        end
        if (!aborted) begin
          #1;
          checkOutput("pmem_stable", 128'({pmem_read, pmem_write, pmem_address}),
                      128'({~w0, w0, a0}));
          if (!m.is_write) pmem_rdata = m.data;
          pmem_resp = 1'b1;
          @(posedge clk);
          #1;
          pmem_resp  = 1'b0;
          pmem_rdata = '0;
        end
        mem_busy = 1'b0;
      end
    end
  end

  // Global time limit so the run always reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset_n    = 1'b1;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_l2_mem_resp", 128'(l2_mem_resp), 128'd0);
    checkOutput("rst_l2_rdata", l2_rdata, 128'd0);
    checkOutput("rst_pmem_read", 128'(pmem_read), 128'd0);
    checkOutput("rst_pmem_write", 128'(pmem_write), 128'd0);
    checkOutput("rst_pmem_address", 128'(pmem_address), 128'd0);
    checkOutput("rst_pmem_wdata", pmem_wdata, 128'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] write to empty buffer, then idle drain");
    expectMem(1'b1, 16'h1230, LINE_A, 3);
    applyStimulus(1'b0, 1'b1, 16'h1230, LINE_A, 1'b0, '0, 1);
    checkOutput("no_early_pmem", 128'(pmem_read || pmem_write), 128'd0);
    idleReq();
    waitQuiet();

    $display("[TB] read hit, read miss, read hit again, then drain");
    expectMem(1'b0, 16'h4000, LINE_M, 5);
    expectMem(1'b1, 16'h1230, LINE_A, 2);
    applyStimulus(1'b0, 1'b1, 16'h1230, LINE_A, 1'b0, '0, 1);
    applyStimulus(1'b1, 1'b0, 16'h123E, '0, 1'b1, LINE_A, 1);
    applyStimulus(1'b1, 1'b0, 16'h4000, '0, 1'b1, LINE_M, 7);
    applyStimulus(1'b1, 1'b0, 16'h1234, '0, 1'b1, LINE_A, 1);
    idleReq();
    waitQuiet();

    $display("[TB] write miss with buffer full");
    expectMem(1'b1, 16'h1230, LINE_A, 2);
    expectMem(1'b1, 16'h5000, LINE_B, 4);
    applyStimulus(1'b0, 1'b1, 16'h1230, LINE_A, 1'b0, '0, 1);
    applyStimulus(1'b0, 1'b1, 16'h5000, LINE_B, 1'b0, '0, 5);
    idleReq();
    waitQuiet();

    $display("[TB] simultaneous read and write");
    expectMem(1'b1, 16'h2000, LINE_C, 1);
    applyStimulus(1'b1, 1'b1, 16'h2000, LINE_C, 1'b0, '0, 1);
    idleReq();
    waitQuiet();

    $display("[TB] reset during drain");
    expectMem(1'b1, 16'h7000, LINE_D, 20);
    applyStimulus(1'b0, 1'b1, 16'h7000, LINE_D, 1'b0, '0, 1);
    idleReq();
    for (int k = 0; k < 20 && !pmem_write; k++) @(negedge clk);
    checkOutput("drain_started", 128'(pmem_write), 128'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("rstmid_pmem_write", 128'(pmem_write), 128'd0);
    checkOutput("rstmid_pmem_address", 128'(pmem_address), 128'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_pmem_write", 128'(pmem_write), 128'd0);
    checkOutput("post_rst_l2_mem_resp", 128'(l2_mem_resp), 128'd0);
    expectMem(1'b0, 16'h7000, LINE_E, 3);
    applyStimulus(1'b1, 1'b0, 16'h7000, '0, 1'b1, LINE_E, 5);
    idleReq();
    waitQuiet();

    repeat (10) @(posedge clk);
    checkOutput("sb_drained", 128'(exp_resp.size() + exp_mem.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

Line-granular responder that answers the victim cache's L2-side request port (read/write, address, 128-bit line, one-cycle response pulse) and forwards traffic to physical memory. A single-entry write buffer absorbs evicted lines so writes complete without waiting on memory. Reads that match the buffered line are served from the buffer; the buffer drains to memory opportunistically when the port is idle. Sits between victim_cache and the physical-memory interface.

## Interface
- No parameters; widths come from lc3b_types (lc3b_word = 16 b, lc3b_cache_line = 128 b).
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- l2_address  in  16  request byte address; line = bits [15:4]
- l2_wdata  in  128  line to write
- l2_read  in  1  read request, level, held until response
- l2_write  in  1  write request, level, held until response
- l2_rdata  out  128  read data, registered, valid while l2_mem_resp=1
- l2_mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  memory line address, bits [3:0] always 0
- pmem_wdata  out  128  memory write data
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_rdata  in  128  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- Buffer entry: valid, tag = address[15:4], data[127:0]. Hit = valid && tag == l2_address[15:4].
- States: IDLE, READ_MEM, DRAIN, RESP.
- IDLE, l2_write, (!valid or hit): capture tag/data, set valid, -> RESP.
- IDLE, l2_write, valid && !hit: -> DRAIN; request waits.
- IDLE, l2_read, hit: l2_rdata <= buffer data, -> RESP.
- IDLE, l2_read, !hit: -> READ_MEM; buffer untouched.
- IDLE, no request, valid: -> DRAIN (opportunistic).
- READ_MEM: pmem_read=1, pmem_address={l2_address[15:4],4'h0}; on pmem_resp latch pmem_rdata into l2_rdata, -> RESP.
- DRAIN: pmem_write=1, pmem_address={tag,4'h0}, pmem_wdata=data; on pmem_resp clear valid, -> IDLE. Requests arriving mid-drain (including read hits) wait.
- RESP: l2_mem_resp=1 for exactly one cycle, -> IDLE.
- l2_read and l2_write both high: illegal; write takes priority.
- pmem_read and pmem_write never asserted together.

## Timing
- Reset (async assert, any state): state=IDLE, valid=0, l2_rdata=0, l2_mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. Buffered line is discarded; pmem strobes drop immediately.
- Write to empty buffer or write/read hit: request sampled at edge N, l2_mem_resp high cycle N+1.
- Read miss: pmem_read high from cycle N+1; pmem_resp at edge M -> l2_mem_resp high cycle M+1.
- Write miss with buffer full: drain (pmem latency), one IDLE cycle, capture, response next cycle.
- Requester must drop l2_read/l2_write in the cycle after l2_mem_resp; the block returns to IDLE at that same edge so the request is not re-sampled.
- Strobes to memory are held stable until pmem_resp; a pmem_resp outside READ_MEM/DRAIN is ignored.

## Structure
- lc3b_types already supplies lc3b_word and lc3b_cache_line; add lc3b_l2wb_state enum (IDLE, READ_MEM, DRAIN, RESP) there.
- One sub-module: write_buffer_entry (valid/tag/data registers, load/clear, combinational hit compare). FSM and output muxing in l2_write_buffer.

## Test plan
- Reset mid-DRAIN: reset_n low while pmem_write=1 -> pmem_write=0 same cycle, valid=0, l2_mem_resp=0 after release.
- Write 0x1230 data A, empty buffer -> l2_mem_resp cycle N+1, no pmem activity until idle; then idle drain writes pmem_address 0x1230 data A.
- Write 0x1230 A then read 0x123E before drain -> l2_rdata=A, l2_mem_resp cycle N+1, no pmem_read.
- Read 0x4000 miss with buffer holding 0x1230, memory latency 5 -> pmem_read at 0x4000, l2_rdata=memory line, buffer still valid at 0x1230.
- Write 0x5000 B with buffer holding 0x1230 A -> pmem_write 0x1230 A completes first, then B captured, l2_mem_resp, later drain of 0x5000 B.
- l2_read and l2_write together at 0x2000 -> treated as write, exactly one l2_mem_resp pulse.
